// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the wait-FSM state encoding and the register-field width used by the hazard checks.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  // $zero is hard-wired, so a load targeting it can never create a real dependency.
  function automatic logic load_use_hit(
    input logic             mem_read,
    input logic [REG_W-1:0] ex_rt,
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt,
    input logic             uses_rt
  );
    return mem_read && (ex_rt != ZERO_REG) &&
           ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counts.
// It holds at all ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_value
);

  logic [W-1:0] r_value;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_value <= '0;
    end else if (i_inc && (r_value != '1)) begin
      r_value <= r_value + 1'b1;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch flushes
// and a bounded memory-wait freeze with timeout, plus saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16,
  parameter int TO_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_ex_mem_read,
  input  logic [REG_W-1:0] i_id_ex_rt,
  input  logic [REG_W-1:0] i_if_id_rs,
  input  logic [REG_W-1:0] i_if_id_rt,
  input  logic             i_if_id_uses_rt,
  input  logic             i_id_branch_taken,
  input  logic             i_ex_mem_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_write,
  output logic             o_id_ex_bubble,
  output logic             o_ex_mem_write,
  output logic             o_mem_wb_bubble,
  output logic             o_busy,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count
);

  localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(TIMEOUT);

  state_t          r_state;
  logic [TO_W-1:0] r_wait_cnt;
  logic            r_mem_err;

  logic w_timeout_hit;
  logic w_mem_freeze;
  logic w_load_use;

  assign w_timeout_hit = (r_state == WAIT) && (r_wait_cnt == TIMEOUT_V);
  assign w_mem_freeze  = i_ex_mem_mem_req && !i_mem_ready && !w_timeout_hit;
  assign w_load_use    = load_use_hit(i_id_ex_mem_read, i_id_ex_rt, i_if_id_rs,
                                      i_if_id_rt, i_if_id_uses_rt);

  // Priority: memory freeze, then load-use stall, then branch flush.
  always_comb begin
    o_pc_write      = 1'b1;
    o_if_id_write   = 1'b1;
    o_if_id_flush   = 1'b0;
    o_id_ex_write   = 1'b1;
    o_id_ex_bubble  = 1'b0;
    o_ex_mem_write  = 1'b1;
    o_mem_wb_bubble = 1'b0;
    if (!i_rst) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_write  = 1'b0;
      o_ex_mem_write = 1'b0;
    end else if (w_mem_freeze) begin
      o_pc_write      = 1'b0;
      o_if_id_write   = 1'b0;
      o_id_ex_write   = 1'b0;
      o_ex_mem_write  = 1'b0;
      o_mem_wb_bubble = 1'b1;
    end else if (w_load_use) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_bubble = 1'b1;
    end else if (i_id_branch_taken) begin
      o_if_id_flush = 1'b1;
    end
  end

  // A dropped request while waiting is abnormal but simply abandons the wait.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_mem_err <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_mem_freeze) begin
            r_state    <= WAIT;
            r_wait_cnt <= TO_W'(1);
          end
        end
        WAIT: begin
          if (!i_ex_mem_mem_req || i_mem_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (w_timeout_hit) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign o_busy    = (r_state == WAIT);
  assign o_mem_err = r_mem_err;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (!o_pc_write),
    .o_value (o_stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (o_if_id_flush),
    .o_value (o_flush_count)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the write-enable and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three conditions: load-use hazards, taken branches, and a multi-cycle data-memory handshake in the MEM stage.
- Holds a bounded wait FSM with timeout, plus saturating stall and flush performance counters.

Parameters:
- TIMEOUT, 255: maximum consecutive memory-wait cycles before a forced release.
- CNT_W, 16: width of the performance counters.
- TO_W, 8: width of the wait counter; TIMEOUT must fit in TO_W bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rt  in  5  destination register of the instruction in EX.
- if_id_rs  in  5  rs field of the instruction in ID.
- if_id_rt  in  5  rt field of the instruction in ID.
- if_id_uses_rt  in  1  the instruction in ID reads rt.
- id_branch_taken  in  1  branch in ID resolved as taken.
- ex_mem_mem_req  in  1  instruction in MEM accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clear.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_bubble  out  1  load zeros into ID/EX control fields.
- ex_mem_write  out  1  EX/MEM load enable.
- mem_wb_bubble  out  1  load zeros into MEM/WB control fields.
- busy  out  1  FSM is in WAIT.
- mem_err  out  1  registered one-cycle pulse on timeout.
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0.
- flush_count  out  CNT_W  saturating count of IF/ID flushes.

Behaviour:
- Reset (rst=0 sampled at a rising edge):
  - state=RUN, wait_cnt=0, mem_err=0, both counters 0.
  - While rst=0, all enables and bubble/flush outputs are forced to 0.
- Control outputs are combinational from state, wait_cnt and the inputs, so they act in the same cycle. Priority: mem_freeze > load_use > branch.
- mem_freeze = ex_mem_mem_req & ~mem_ready & ~(state==WAIT & wait_cnt==TIMEOUT).
  - While asserted: pc_write, if_id_write, id_ex_write and ex_mem_write are 0; mem_wb_bubble=1; if_id_flush=0; id_ex_bubble=0.
- load_use = id_ex_mem_read & id_ex_rt!=0 & (id_ex_rt==if_id_rs | (if_id_uses_rt & id_ex_rt==if_id_rt)).
  - When load_use and no freeze: pc_write=0, if_id_write=0, id_ex_bubble=1; ID/EX and EX/MEM keep loading.
  - A taken branch in the same cycle is ignored; the branch is re-evaluated after the stall.
- Branch (id_branch_taken, no freeze, no load_use): if_id_flush=1; everything else loads normally.
- Otherwise: all write enables are 1 and all bubble/flush outputs are 0.
- FSM states:
  - RUN to WAIT when mem_freeze; wait_cnt goes to 1.
  - In WAIT, if mem_ready, go to RUN and clear wait_cnt; the pipeline advances in that same cycle.
  - In WAIT with wait_cnt<TIMEOUT and no ready: stay and increment wait_cnt.
  - In WAIT with wait_cnt==TIMEOUT: freeze is released this cycle, mem_err=1 on the next cycle, FSM goes to RUN, wait_cnt is cleared.
  - If ex_mem_mem_req drops while in WAIT (abnormal), go to RUN and clear wait_cnt.
- busy = (state==WAIT).
- Counters:
  - stall_count increments on every cycle with pc_write=0, after reset.
  - flush_count increments on every cycle with if_id_flush=1.
  - Both saturate at all ones and never wrap.
- Reset in the middle of a wait: the FSM returns to RUN on that edge and no mem_err is produced.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum {RUN, WAIT}.
  - register-index width constant REG_W=5.
  - constant ZERO_REG=5'd0.
- One natural sub-module: sat_counter (parameter W, inputs inc and rst, output value that saturates at all ones), instantiated twice.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_rt=8, if_id_rs=8 -> pc_write=0, if_id_write=0, id_ex_bubble=1 for one cycle; stall_count=1.
- Zero register: id_ex_rt=0, if_id_rs=0 with a load in EX -> no stall; all enables 1.
- Branch plus load-use in the same cycle -> id_ex_bubble=1, if_id_flush=0. Next cycle, with the branch still taken and no hazard -> if_id_flush=1, flush_count=1.
- Memory wait: ex_mem_mem_req=1, mem_ready=0 for 3 cycles then 1 -> enables 0 and busy=1 for exactly 3 cycles, advance on the 4th, stall_count=3.
- Timeout: with TIMEOUT=4, mem_ready held at 0 -> freeze on cycles 1-4, release on cycle 5, single mem_err pulse on cycle 6, state back to RUN.
- Reset mid-wait: rst=0 at wait_cnt=2 -> next cycle state=RUN, counters 0, mem_err never asserted.
